// File: rtl/jk_flipflop_five_bit_downcounter.sv
// Five-bit synchronous down counter whose state is held in JK flip-flops.
// Each bit's J/K inputs are formed from the borrow chain. Every flip-flop
// shares one clock, so no bit is clocked by another bit's output.
// Loads and wraps drive J/K as set/clear pairs. Decrements drive J=K=1 on
// the bits that must toggle.

// Single JK flip-flop with synchronous active-high reset.
module jk_ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

module jk_flipflop_five_bit_downcounter #(
    parameter logic [4:0] WRAP_VALUE = 5'd31
) (
    input  logic       clockPulse,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [4:0] loadValue,
    input  logic       holdAtZero,
    output logic [4:0] Result,
    output logic       zero,
    output logic       borrowOut
);

    logic [4:0] w_q;
    logic [4:0] w_borrow_chain;
    logic [4:0] w_j;
    logic [4:0] w_k;
    logic       w_zero;
    logic       w_wrap;
    logic       r_borrow;

    assign w_zero = (w_q == 5'd0);

    // A wrap happens only on a decrement edge at count 0 in wrap mode.
    // holdAtZero is therefore only looked at on that edge.
    assign w_wrap = enable & ~load & w_zero & ~holdAtZero;

    // Ripple-borrow chain: bit i toggles when all lower bits are 0.
    always_comb begin
        w_borrow_chain[0] = 1'b1;
        for (int i = 1; i < 5; i++) begin
            w_borrow_chain[i] = w_borrow_chain[i-1] & ~w_q[i-1];
        end
    end

    // J/K steering. Load has priority, then decrement, then hold.
    // The synchronous reset lives inside each flip-flop and overrides all of these.
    always_comb begin
        w_j = 5'd0;
        w_k = 5'd0;
        if (load) begin
            w_j = loadValue;
            w_k = ~loadValue;
        end else if (enable) begin
            if (!w_zero) begin
                w_j = w_borrow_chain;
                w_k = w_borrow_chain;
            end else if (!holdAtZero) begin
                w_j = WRAP_VALUE;
                w_k = ~WRAP_VALUE;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_bit
            jk_ff u_jk (
                .i_clk (clockPulse),
                .i_rst (reset),
                .i_j   (w_j[g]),
                .i_k   (w_k[g]),
                .o_q   (w_q[g])
            );
        end
    endgenerate

    // borrowOut is registered. It is high for the one cycle after each wrap edge.
    always_ff @(posedge clockPulse) begin
        if (reset) begin
            r_borrow <= 1'b0;
        end else begin
            r_borrow <= w_wrap;
        end
    end

    assign Result    = w_q;
    assign zero      = w_zero;
    assign borrowOut = r_borrow;

endmodule

// File: tb/tb_jk_flipflop_five_bit_downcounter.sv
// Directed bench for the JK five-bit down counter.
// A second instance uses WRAP_VALUE=0 to exercise back-to-back wraps.
module tb_jk_flipflop_five_bit_downcounter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [4:0] ld_val;
  logic       hold;
  logic [4:0] result;
  logic       zero;
  logic       borrow;

  logic       rst_w0;
  logic       en_w0;
  logic       ld_w0;
  logic [4:0] ld_val_w0;
  logic       hold_w0;
  logic [4:0] result_w0;
  logic       zero_w0;
  logic       borrow_w0;

  int n_checks;
  int n_errors;

  logic [4:0] exp_q[$];
  int         visits[32];
  int         pulses;
  logic [4:0] e;

  jk_flipflop_five_bit_downcounter u_dut (
    .clockPulse (clk),
    .reset      (rst),
    .enable     (en),
    .load       (ld),
    .loadValue  (ld_val),
    .holdAtZero (hold),
    .Result     (result),
    .zero       (zero),
    .borrowOut  (borrow)
  );

  jk_flipflop_five_bit_downcounter #(.WRAP_VALUE(5'd0)) u_dut_w0 (
    .clockPulse (clk),
    .reset      (rst_w0),
    .enable     (en_w0),
    .load       (ld_w0),
    .loadValue  (ld_val_w0),
    .holdAtZero (hold_w0),
    .Result     (result_w0),
    .zero       (zero_w0),
    .borrowOut  (borrow_w0)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic [4:0] v,
                       input logic en_i, input logic h);
    rst    = r;
    ld     = l;
    ld_val = v;
    en     = en_i;
    hold   = h;
  endtask

  task automatic expect_state(input string tag, input logic [4:0] r,
                              input logic z, input logic b);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_zero"},   32'(zero),   32'(z));
    chk({tag, "_borrow"}, 32'(borrow), 32'(b));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_w0    = 1'b1;
    en_w0     = 1'b0;
    ld_w0     = 1'b0;
    ld_val_w0 = 5'd0;
    hold_w0   = 1'b0;

    // reset
    tick();
    expect_state("reset", 5'd0, 1'b1, 1'b0);
    chk("w0_reset_result", 32'(result_w0), 32'd0);
    chk("w0_reset_borrow", 32'(borrow_w0), 32'd0);

    // load 5 then count down through the wrap
    drive(1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    tick();
    expect_state("load5", 5'd5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick(); expect_state("dec4",  5'd4,  1'b0, 1'b0);
    tick(); expect_state("dec3",  5'd3,  1'b0, 1'b0);
    tick(); expect_state("dec2",  5'd2,  1'b0, 1'b0);
    tick(); expect_state("dec1",  5'd1,  1'b0, 1'b0);
    tick(); expect_state("dec0",  5'd0,  1'b1, 1'b0);
    tick(); expect_state("wrap31", 5'd31, 1'b0, 1'b1);

    // disable: value holds and the borrow pulse ends
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); expect_state("idle_hold", 5'd31, 1'b0, 1'b0);

    // saturate at zero
    drive(1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick(); expect_state("load0", 5'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state("sat0", 5'd0, 1'b1, 1'b0);
    end

    // holdAtZero is ignored away from zero
    drive(1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick(); expect_state("hold_ignored", 5'd1, 1'b0, 1'b0);

    // four-bit borrow ripple, and 1 -> 0
    drive(1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick(); expect_state("dec16", 5'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick(); expect_state("dec1to0", 5'd0, 1'b1, 1'b0);

    // wrap, then load on the following edge clears the borrow
    tick(); expect_state("wrap_again", 5'd31, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    tick(); expect_state("load_clears_borrow", 5'd7, 1'b0, 1'b0);

    // load beats enable on the same edge
    drive(1'b0, 1'b1, 5'd20, 1'b1, 1'b0);
    tick(); expect_state("load_over_en", 5'd20, 1'b0, 1'b0);

    // reset beats load and enable
    drive(1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick(); expect_state("rst_over_all", 5'd0, 1'b1, 1'b0);

    // free run from 31 for 64 cycles
    drive(1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
    tick(); expect_state("load31", 5'd31, 1'b0, 1'b0);
    e = 5'd31;
    for (int i = 0; i < 64; i++) begin
      e = (e == 5'd0) ? 5'd31 : e - 5'd1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 32; i++) visits[i] = 0;
    pulses = 0;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      chk("free_result", 32'(result), 32'(e));
      chk("free_borrow", 32'(borrow), 32'(e == 5'd31));
      visits[result]++;
      if (borrow) pulses++;
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) if (visits[i] != 2) bad++;
      chk("free_visits_not_two", 32'(bad), 32'd0);
    end
    chk("free_pulses", 32'(pulses), 32'd2);

    // WRAP_VALUE=0: continuous wraps keep borrowOut high
    rst_w0 = 1'b0;
    en_w0  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w0_result", 32'(result_w0), 32'd0);
      chk("w0_zero",   32'(zero_w0),   32'd1);
      chk("w0_borrow", 32'(borrow_w0), 32'd1);
    end
    en_w0 = 1'b0;
    tick();
    chk("w0_borrow_off", 32'(borrow_w0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jk_flipflop_five_bit_downcounter.md
JK_FLIPFLOP_FIVE_BIT_DOWNCOUNTER -- requirements
Module: jk_flipflop_five_bit_downcounter

Interface
REQ-001 Parameter: WRAP_VALUE, default 5'd31, value loaded when a decrement occurs at count 0 in wrap mode.
REQ-002 clockPulse  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  count-down enable; one decrement per clockPulse edge while high.
REQ-005 load  input  1  parallel-load strobe.
REQ-006 loadValue  input  5  value captured on load.
REQ-007 holdAtZero  input  1  1 = saturate at 0; 0 = wrap to WRAP_VALUE.
REQ-008 Result  output  5  current count; bit 0 = LSB.
REQ-009 zero  output  1  combinational, high when Result == 0.
REQ-010 borrowOut  output  1  registered one-cycle pulse marking a wrap.

Function
REQ-011 Count state SHALL be five JK flip-flops; each bit toggles (J=K=1) when enabled and all lower bits are 0 (ripple-borrow AND chain on inverted lower outputs); bit 0 toggles on every enabled decrement.
REQ-012 Per-edge priority SHALL be reset > load > enable > hold.
REQ-013 load=1: Result SHALL equal loadValue after the edge, regardless of enable or holdAtZero; borrowOut SHALL be 0 after that edge.
REQ-014 enable=1, load=0, Result>0: Result SHALL become Result-1 after the edge; borrowOut 0.
REQ-015 enable=1, load=0, Result=0, holdAtZero=1: Result SHALL stay 0; borrowOut 0.
REQ-016 enable=1, load=0, Result=0, holdAtZero=0: Result SHALL become WRAP_VALUE; borrowOut SHALL be 1 for exactly the following cycle.
REQ-017 enable=0, load=0: Result SHALL hold; borrowOut 0.
REQ-018 Decrement latency SHALL be one clock; Result SHALL be glitch-free registered state (no asynchronous ripple clocking).
REQ-019 zero SHALL track Result combinationally with no added latency.
REQ-020 holdAtZero SHALL be sampled only on the edge where Result=0 and a decrement is requested; changes at other times have no effect.
REQ-021 Consecutive wraps (e.g. WRAP_VALUE=0, continuous enable, holdAtZero=0) SHALL keep borrowOut high every cycle.
REQ-022 All arithmetic SHALL be modulo 32; no output other than Result, zero, borrowOut.

Reset
REQ-023 reset=1 at an edge SHALL set Result=5'd0 and borrowOut=0, overriding load and enable.
REQ-024 After reset, zero SHALL be 1.
REQ-025 Reset asserted mid-count SHALL take effect at the next edge; no partial decrement SHALL be visible.
REQ-026 On first edge after reset release, normal priority (REQ-012) SHALL apply.

Verification
REQ-027 reset 1 cycle, load=1 loadValue=5 then enable=1 for 6 cycles, holdAtZero=0 -> Result 5,4,3,2,1,0,31; zero high at count 0; borrowOut high only the cycle Result=31.
REQ-028 Result=0, holdAtZero=1, enable=1 for 3 cycles -> Result stays 0, zero=1, borrowOut=0.
REQ-029 Result=16, enable=1 -> Result=15 (four-bit borrow ripple); Result=1 -> 0.
REQ-030 load=1 loadValue=20 with enable=1 same edge -> Result=20, not 19; borrowOut=0.
REQ-031 reset=1 with load=1 loadValue=9 and enable=1 at Result=12 -> Result=0, borrowOut=0, zero=1.
REQ-032 Free-run enable=1 from 31, holdAtZero=0, 64 cycles -> every value 31..0 visited twice, exactly 2 borrowOut pulses.
